flex_timer: RTL and testbench

Parametrised, programmable counter/timer, next generation of the team's flexible counter. Adds an enable prescaler, up/down direction, parallel load, one-shot vs. free-running mode, and a single-cycle rollover pulse alongside the level flag. Used wherever USB/AHB logic needs bit-period, timeout or byte counting with a run-time programmable period.

---
 rtl/flex_timer_pkg.sv | 21 ++
 rtl/flex_timer_if.sv | 42 ++++
 rtl/tick_prescaler.sv | 39 +++
 rtl/flex_timer.sv | 110 +++++++++++
 tb/tb_flex_timer.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/flex_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flex_timer_pkg
// Purpose  : Shared types and default widths for the flex_timer block.
//            Provides the one-shot FSM state type and the default counter
//            and prescaler widths used by the interface and the RTL.
// Revision : 1.0 - initial release
// ============================================================================
package flex_timer_pkg;

    localparam int c_DEF_NUM_CNT_BITS  = 8;
    localparam int c_DEF_PRESCALE_BITS = 4;

    // RUN: counting normally. DONE: one-shot terminal value reached, parked.
    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } flex_timer_state_t;

endpackage : flex_timer_pkg
`default_nettype wire

// File: rtl/flex_timer_if.sv
`default_nettype none
// ============================================================================
// Module   : flex_timer_if
// Purpose  : Control/status bundle of the flex_timer.
//            master : drives clear, count_enable, prescale_val, count_down,
//                     one_shot, load, load_val, rollover_val; observes status.
//            slave  : the timer; drives count_out, rollover_flag,
//                     rollover_pulse, done.
// Revision : 1.0 - initial release
// ============================================================================
interface flex_timer_if
    import flex_timer_pkg::*;
#(
    parameter int NUM_CNT_BITS  = c_DEF_NUM_CNT_BITS,
    parameter int PRESCALE_BITS = c_DEF_PRESCALE_BITS
);
    logic                     clear;
    logic                     count_enable;
    logic [PRESCALE_BITS-1:0] prescale_val;
    logic                     count_down;
    logic                     one_shot;
    logic                     load;
    logic [NUM_CNT_BITS-1:0]  load_val;
    logic [NUM_CNT_BITS-1:0]  rollover_val;
    logic [NUM_CNT_BITS-1:0]  count_out;
    logic                     rollover_flag;
    logic                     rollover_pulse;
    logic                     done;

    modport master (
        output clear, count_enable, prescale_val, count_down, one_shot,
               load, load_val, rollover_val,
        input  count_out, rollover_flag, rollover_pulse, done
    );

    modport slave (
        input  clear, count_enable, prescale_val, count_down, one_shot,
               load, load_val, rollover_val,
        output count_out, rollover_flag, rollover_pulse, done
    );
endinterface : flex_timer_if
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
// Module   : tick_prescaler
// Purpose  : Enable prescaler. Emits tick_o on every (prescale_val+1)-th
//            cycle in which enable_i is high; enable_i low freezes it.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            clear_i       - restart the prescale count at 0
//            enable_i      - qualifies advance
//            prescale_val  - period minus one
//            tick_o        - combinational tick for the current cycle
// Revision : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import flex_timer_pkg::*;
#(
    parameter int PRESCALE_BITS = c_DEF_PRESCALE_BITS
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     clear_i,
    input  wire logic                     enable_i,
    input  wire logic [PRESCALE_BITS-1:0] prescale_val,
    output      logic                     tick_o
);
    logic [PRESCALE_BITS-1:0] r_cnt;

    // The tick is decoded from the current count so that prescale_val = 0
    // advances the main counter on the very edge count_enable is seen.
    assign tick_o = enable_i && (r_cnt == prescale_val);

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            r_cnt <= '0;
        end else if (enable_i) begin
            r_cnt <= tick_o ? '0 : r_cnt + 1'b1;
        end
    end
endmodule : tick_prescaler
`default_nettype wire

// File: rtl/flex_timer.sv
`default_nettype none
// ============================================================================
// Module   : flex_timer
// Purpose  : Programmable up/down counter/timer with prescaler, parallel
//            load, one-shot/free-running modes, rollover level flag and a
//            single-cycle rollover pulse. All outputs are registered.
// Ports    : clk, rst  - clock, synchronous active-high reset
//            bus       - flex_timer_if.slave (controls in, status out)
// Revision : 1.0 - initial release
// ============================================================================
module flex_timer
    import flex_timer_pkg::*;
#(
    parameter int NUM_CNT_BITS  = c_DEF_NUM_CNT_BITS,
    parameter int PRESCALE_BITS = c_DEF_PRESCALE_BITS
) (
    input wire logic    clk,
    input wire logic    rst,
    flex_timer_if.slave bus
);
    localparam logic [NUM_CNT_BITS-1:0] c_ONE = NUM_CNT_BITS'(1);

    flex_timer_state_t       r_state;
    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    r_flag;
    logic                    r_pulse;
    logic                    r_done;

    logic                    w_tick;
    logic                    w_rzero;
    logic [NUM_CNT_BITS-1:0] w_term;
    logic [NUM_CNT_BITS-1:0] w_next;
    logic                    w_hit;
    logic                    w_load_hit;

    tick_prescaler #(
        .PRESCALE_BITS (PRESCALE_BITS)
    ) u_prescaler (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (bus.clear | bus.load),
        .enable_i     (bus.count_enable),
        .prescale_val (bus.prescale_val),
        .tick_o       (w_tick)
    );

    // A zero period pins the count at 0 and suppresses flag/pulse entirely,
    // so every terminal-value match below is qualified with !w_rzero.
    assign w_rzero = (bus.rollover_val == '0);
    assign w_term  = bus.count_down ? c_ONE : bus.rollover_val;

    always_comb begin
        w_next = '0;
        if (w_rzero) begin
            w_next = '0;
        end else if (!bus.count_down) begin
            // ">=" rather than "==" so a load above the period wraps to 1.
            w_next = (r_count >= bus.rollover_val) ? c_ONE : r_count + 1'b1;
        end else begin
            w_next = (r_count <= c_ONE) ? bus.rollover_val : r_count - 1'b1;
        end
    end

    assign w_hit      = !w_rzero && (w_next == w_term);
    assign w_load_hit = !w_rzero && (bus.load_val == w_term);

    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            r_state <= RUN;
            r_count <= '0;
            r_flag  <= 1'b0;
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.load) begin
            r_state <= RUN;
            r_count <= bus.load_val;
            r_flag  <= w_load_hit;
            r_pulse <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            case (r_state)
                RUN: begin
                    if (w_tick) begin
                        r_count <= w_next;
                        r_flag  <= w_hit;
                        r_pulse <= w_hit;
                        if (bus.one_shot && w_hit) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Parked at the terminal value; only clear/load leave.
                    r_done <= 1'b1;
                end
                default: begin
                    r_state <= RUN;
                end
            endcase
        end
    end

    assign bus.count_out      = r_count;
    assign bus.rollover_flag  = r_flag;
    assign bus.rollover_pulse = r_pulse;
    assign bus.done           = r_done;
endmodule : flex_timer
`default_nettype wire

// File: tb/tb_flex_timer.sv
`default_nettype none
// ============================================================================
// Module   : tb_flex_timer
// Purpose  : Self-checking bench for flex_timer. A cycle-level reference
//            model is compared against the DUT every cycle, and directed
//            sequences pin literal expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flex_timer;
    localparam int NB = 8;
    localparam int PB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    flex_timer_if #(.NUM_CNT_BITS(NB), .PRESCALE_BITS(PB)) tif ();

    flex_timer #(.NUM_CNT_BITS(NB), .PRESCALE_BITS(PB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    // ---------------- reference model ----------------
    int m_cnt  = 0;
    int m_pre  = 0;
    bit m_flag = 0;
    bit m_pulse = 0;
    bit m_done = 0;

    always @(posedge clk) begin
        int  r, p, term, n;
        bit  tick;
        r    = int'(tif.rollover_val);
        p    = int'(tif.prescale_val);
        term = tif.count_down ? 1 : r;
        tick = tif.count_enable && (m_pre == p);
        if (rst || tif.clear) begin
            m_cnt = 0; m_pre = 0; m_flag = 0; m_pulse = 0; m_done = 0;
        end else if (tif.load) begin
            m_cnt   = int'(tif.load_val);
            m_pre   = 0;
            m_flag  = (r != 0) && (m_cnt == term);
            m_pulse = 0;
            m_done  = 0;
        end else begin
            if (tif.count_enable) m_pre = tick ? 0 : m_pre + 1;
            m_pulse = 0;
            if (tick && !m_done) begin
                if (r == 0)               n = 0;
                else if (!tif.count_down) n = (m_cnt >= r) ? 1 : m_cnt + 1;
                else                      n = (m_cnt <= 1) ? r : m_cnt - 1;
                m_cnt   = n;
                m_flag  = (r != 0) && (n == term);
                m_pulse = m_flag;
                if (tif.one_shot && m_flag) m_done = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_count", 32'(tif.count_out), 32'(m_cnt));
        chk("model_flag",  32'(tif.rollover_flag), 32'(m_flag));
        chk("model_pulse", 32'(tif.rollover_pulse), 32'(m_pulse));
        chk("model_done",  32'(tif.done), 32'(m_done));
    end

    // ---------------- directed stimulus ----------------
    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic lit(input string nm, input int c, input bit f, input bit p, input bit d);
        chk({nm, "_count"}, 32'(tif.count_out), 32'(c));
        chk({nm, "_flag"},  32'(tif.rollover_flag), 32'(f));
        chk({nm, "_pulse"}, 32'(tif.rollover_pulse), 32'(p));
        chk({nm, "_done"},  32'(tif.done), 32'(d));
    endtask

    initial begin
        int down_seq[6];
        down_seq = '{5, 4, 3, 2, 1, 5};

        tif.clear = 0; tif.count_enable = 0; tif.prescale_val = '0;
        tif.count_down = 0; tif.one_shot = 0; tif.load = 0;
        tif.load_val = '0; tif.rollover_val = '0;

        repeat (2) nxt();
        lit("reset", 0, 0, 0, 0);

        // Up, R=4, P=0
        rst = 0; tif.rollover_val = 4; tif.count_enable = 1;
        for (int i = 0; i < 8; i++) begin
            int e;
            e = (i % 4) + 1;
            nxt();
            lit("up_r4", e, e == 4, e == 4, 0);
        end

        // Clear, then P=2, R=3 with an enable gap
        tif.clear = 1; nxt(); lit("clear", 0, 0, 0, 0);
        tif.clear = 0; tif.prescale_val = 2; tif.rollover_val = 3;
        nxt(); lit("pre_a", 0, 0, 0, 0);
        nxt(); lit("pre_b", 0, 0, 0, 0);
        nxt(); lit("pre_tick", 1, 0, 0, 0);
        nxt(); lit("pre_c", 1, 0, 0, 0);
        tif.count_enable = 0;
        nxt(); nxt(); lit("pre_frozen", 1, 0, 0, 0);
        tif.count_enable = 1;
        nxt(); lit("pre_resume", 1, 0, 0, 0);
        nxt(); lit("pre_delayed", 2, 0, 0, 0);
        nxt(); nxt(); lit("pre_d", 2, 0, 0, 0);
        nxt(); lit("pre_term", 3, 1, 1, 0);
        nxt(); lit("pre_pulse_w", 3, 1, 0, 0);

        // Down, R=5 from reset, then load 9
        rst = 1; nxt(); lit("rst2", 0, 0, 0, 0);
        rst = 0; tif.count_down = 1; tif.rollover_val = 5; tif.prescale_val = 0;
        for (int i = 0; i < 6; i++) begin
            nxt();
            lit("down_r5", down_seq[i], down_seq[i] == 1, down_seq[i] == 1, 0);
        end
        tif.load = 1; tif.load_val = 9; nxt(); lit("load9", 9, 0, 0, 0);
        tif.load = 0;
        for (int e = 8; e >= 1; e--) begin
            nxt();
            lit("down_9", e, e == 1, e == 1, 0);
        end

        // One-shot up, R=3
        rst = 1; tif.count_down = 0; tif.one_shot = 1; tif.rollover_val = 3;
        nxt(); lit("rst3", 0, 0, 0, 0);
        rst = 0;
        nxt(); lit("os_1", 1, 0, 0, 0);
        nxt(); lit("os_2", 2, 0, 0, 0);
        nxt(); lit("os_3", 3, 1, 1, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) tif.one_shot = 0;
            nxt(); lit("os_hold", 3, 1, 0, 1);
        end
        tif.one_shot = 1; tif.load = 1; tif.load_val = 0;
        nxt(); lit("os_load", 0, 0, 0, 0);
        tif.load = 0;
        nxt(); lit("os_r1", 1, 0, 0, 0);
        nxt(); lit("os_r2", 2, 0, 0, 0);
        nxt(); lit("os_r3", 3, 1, 1, 1);

        // Priority
        tif.clear = 1; tif.load = 1; tif.load_val = 7;
        nxt(); lit("clr_ld_tick", 0, 0, 0, 0);
        tif.clear = 0; tif.load = 0; tif.one_shot = 0;
        nxt(); lit("after_clr", 1, 0, 0, 0);
        tif.rollover_val = 7; tif.load = 1;
        nxt(); lit("ld_tick", 7, 1, 0, 0);
        tif.load = 0;
        nxt(); lit("wrap_after_ld", 1, 0, 0, 0);
        tif.rollover_val = 0;
        for (int i = 0; i < 5; i++) begin
            nxt(); lit("r_zero", 0, 0, 0, 0);
        end

        // Reset mid-count (P=1, R=8) and in DONE
        tif.clear = 1; nxt(); lit("clear2", 0, 0, 0, 0);
        tif.clear = 0; tif.rollover_val = 8; tif.prescale_val = 1;
        repeat (12) nxt();
        lit("at6", 6, 0, 0, 0);
        nxt(); lit("at6_mid", 6, 0, 0, 0);
        rst = 1; nxt(); lit("rst_mid", 0, 0, 0, 0);
        rst = 0;
        nxt(); lit("pre_restart", 0, 0, 0, 0);
        nxt(); lit("pre_restart_tick", 1, 0, 0, 0);
        tif.prescale_val = 0; tif.rollover_val = 2; tif.one_shot = 1;
        nxt(); lit("done_r2", 2, 1, 1, 1);
        nxt(); lit("done_hold", 2, 1, 0, 1);
        rst = 1; nxt(); lit("rst_done", 0, 0, 0, 0);
        rst = 0;
        nxt(); lit("after_rst_done", 1, 0, 0, 0);

        nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule : tb_flex_timer
`default_nettype wire
